// File: rtl/riscv_m_pkg.sv
// riscv_m_pkg
// Shared definitions for the M-extension multiply/divide unit: funct3 op
// encodings, the MDU state type and small decode helpers used by the top
// level to classify an incoming operation.
package riscv_m_pkg;

  localparam logic [2:0] M_MUL    = 3'b000;
  localparam logic [2:0] M_MULH   = 3'b001;
  localparam logic [2:0] M_MULHSU = 3'b010;
  localparam logic [2:0] M_MULHU  = 3'b011;
  localparam logic [2:0] M_DIV    = 3'b100;
  localparam logic [2:0] M_DIVU   = 3'b101;
  localparam logic [2:0] M_REM    = 3'b110;
  localparam logic [2:0] M_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } mdu_state_t;

  // All divide/remainder ops share funct3[2] = 1.
  function automatic logic is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  // rs1 is treated as two's complement for these ops.
  function automatic logic is_signed_a(input logic [2:0] f3);
    return (f3 == M_MUL) || (f3 == M_MULH) || (f3 == M_MULHSU) ||
           (f3 == M_DIV) || (f3 == M_REM);
  endfunction

  // rs2 is treated as two's complement for these ops (MULHSU excluded).
  function automatic logic is_signed_b(input logic [2:0] f3);
    return (f3 == M_MUL) || (f3 == M_MULH) || (f3 == M_DIV) || (f3 == M_REM);
  endfunction

endpackage

// File: rtl/riscv_mdu_step.sv
// mdu_step
// Combinational datapath slice retiring BITS_PER_CYCLE bits per call.
//   isDiv    : 1 = restoring shift-subtract, 0 = shift-add multiply
//   accIn    : multiply {partial product high, multiplier}; divide low half
//              holds dividend bits shifting out / quotient bits shifting in
//   remIn    : divide partial remainder (XLEN+1 bits)
//   operand  : multiplicand magnitude (multiply) or divisor magnitude (divide)
//   accOut/remOut : values after BITS_PER_CYCLE steps
module mdu_step #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                isDiv,
  input  logic [2*XLEN-1:0]   accIn,
  input  logic [XLEN:0]       remIn,
  input  logic [XLEN-1:0]     operand,
  output logic [2*XLEN-1:0]   accOut,
  output logic [XLEN:0]       remOut
);

  logic [2*XLEN-1:0] a;
  logic [XLEN:0]     r;
  logic [XLEN+1:0]   sh;
  logic [XLEN+1:0]   diff;
  logic [XLEN:0]     sum;

  // Unrolled chain of single-bit steps. Divide: bring the next dividend bit
  // into the remainder, keep the subtraction only when it does not go
  // negative. Multiply: conditionally add the multiplicand into the high half
  // and shift the whole accumulator right, consuming one multiplier bit.
  always_comb begin
    a    = accIn;
    r    = remIn;
    sh   = '0;
    diff = '0;
    sum  = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (isDiv) begin
        sh   = {r, a[XLEN-1]};
        diff = sh - {2'b00, operand};
        if (!diff[XLEN+1]) begin
          r              = diff[XLEN:0];
          a[XLEN-1:0]    = {a[XLEN-2:0], 1'b1};
        end else begin
          r              = sh[XLEN:0];
          a[XLEN-1:0]    = {a[XLEN-2:0], 1'b0};
        end
      end else begin
        sum = {1'b0, a[2*XLEN-1:XLEN]} + (a[0] ? {1'b0, operand} : {(XLEN+1){1'b0}});
        a   = {sum, a[XLEN-1:1]};
      end
    end
    accOut = a;
    remOut = r;
  end

endmodule

// File: rtl/riscv_mdu.sv
// riscv_mdu
// Iterative RV32M/RV64M multiply/divide unit. Accepts one op from Execute,
// stalls the front end via MulBusy while iterating, then pulses MulDone for
// one cycle with the result and destination tag.
//   clk, reset (sync, active-high)
//   StartE, funct3E, SrcAE, SrcBE, RdE : issue request from Execute
//   Flush                              : abort in-flight / pending op
//   MulBusy                            : stall request to hazard unit
//   MulDone, MulResult, MulRd          : result pulse (zero outside DONE)
module riscv_mdu
  import riscv_m_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StartE,
  input  logic [2:0]      funct3E,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  input  logic [4:0]      RdE,
  input  logic            Flush,
  output logic            MulBusy,
  output logic            MulDone,
  output logic [XLEN-1:0] MulResult,
  output logic [4:0]      MulRd
);

  localparam int N  = XLEN / BITS_PER_CYCLE;
  localparam int CW = $clog2(N);

  mdu_state_t        state, nextState;
  logic [CW-1:0]     count;
  logic [2*XLEN-1:0] acc, stepAcc;
  logic [XLEN:0]     rem, stepRem;
  logic [XLEN-1:0]   operand;
  logic [2:0]        funct3Q;
  logic [4:0]        rdQ;
  logic              negRes;

  logic              accept, signA, signB, divZero, divOvf, fastPath, lastIter;
  logic              divOpE, divQ, doneValid, negResE;
  logic [XLEN-1:0]   magA, magB;
  logic [2*XLEN-1:0] prodFix;
  logic [XLEN-1:0]   quotFix, remFix, resultMux;

  // Issue-side decode: magnitudes, result sign, and the divide corner cases
  // that skip iteration entirely.
  assign divOpE   = is_div(funct3E);
  assign signA    = is_signed_a(funct3E) & SrcAE[XLEN-1];
  assign signB    = is_signed_b(funct3E) & SrcBE[XLEN-1];
  assign magA     = signA ? -SrcAE : SrcAE;
  assign magB     = signB ? -SrcBE : SrcBE;
  assign negResE  = (funct3E == M_REM) ? signA : (signA ^ signB);
  assign divZero  = divOpE && (SrcBE == '0);
  assign divOvf   = divOpE && is_signed_a(funct3E) &&
                    (SrcAE == {1'b1, {(XLEN-1){1'b0}}}) && (SrcBE == '1);
  assign fastPath = divZero || divOvf;
  assign accept   = (state == IDLE) && StartE && !Flush;
  assign lastIter = (count == CW'(N - 1));
  assign divQ     = is_div(funct3Q);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // Next state and handshake outputs. MulBusy is combinational in the issue
  // cycle so the pipeline stalls immediately. A Flush arriving in DONE
  // suppresses the pulse for the aborted op.
  always_comb begin
    nextState = state;
    MulBusy   = 1'b0;
    doneValid = 1'b0;
    case (state)
      IDLE: begin
        MulBusy = accept;
        if (accept) nextState = fastPath ? DONE : CALC;
      end
      CALC: begin
        MulBusy = 1'b1;
        if (Flush)         nextState = IDLE;
        else if (lastIter) nextState = DONE;
      end
      DONE: begin
        doneValid = !Flush;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Operand capture and iteration. Fast-path results are preloaded so that
  // the normal result mux (with no sign fix-up) yields the required values.
  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      acc     <= '0;
      rem     <= '0;
      operand <= '0;
      funct3Q <= M_MUL;
      rdQ     <= '0;
      negRes  <= 1'b0;
    end else if (accept) begin
      count   <= '0;
      funct3Q <= funct3E;
      rdQ     <= RdE;
      operand <= divOpE ? magB : magA;
      if (divZero) begin
        acc    <= {{XLEN{1'b0}}, {XLEN{1'b1}}};
        rem    <= {1'b0, SrcAE};
        negRes <= 1'b0;
      end else if (divOvf) begin
        acc    <= {{XLEN{1'b0}}, SrcAE};
        rem    <= '0;
        negRes <= 1'b0;
      end else begin
        acc    <= {{XLEN{1'b0}}, divOpE ? magA : magB};
        rem    <= '0;
        negRes <= negResE;
      end
    end else if (state == CALC) begin
      acc   <= stepAcc;
      rem   <= stepRem;
      count <= (Flush || lastIter) ? '0 : count + 1'b1;
    end
  end

  mdu_step #(
    .XLEN          (XLEN),
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) u_step (
    .isDiv  (divQ),
    .accIn  (acc),
    .remIn  (rem),
    .operand(operand),
    .accOut (stepAcc),
    .remOut (stepRem)
  );

  // Sign correction and result selection, gated to zero outside DONE.
  always_comb begin
    prodFix = negRes ? -acc : acc;
    quotFix = negRes ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    remFix  = negRes ? -rem[XLEN-1:0] : rem[XLEN-1:0];
    case (funct3Q)
      M_MUL:                     resultMux = prodFix[XLEN-1:0];
      M_MULH, M_MULHSU, M_MULHU: resultMux = prodFix[2*XLEN-1:XLEN];
      M_DIV, M_DIVU:             resultMux = quotFix;
      default:                   resultMux = remFix;
    endcase
  end

  assign MulDone   = doneValid;
  assign MulResult = doneValid ? resultMux : '0;
  assign MulRd     = doneValid ? rdQ : '0;

endmodule

// File: tb/tb_riscv_mdu.sv
// tb_riscv_mdu
// Directed checks of riscv_mdu at XLEN=32/radix-2 and XLEN=64/4 bits per
// cycle, plus a short mixed sweep compared against a behavioural model.
module tb_riscv_mdu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, flush;

  logic        start32, busy32, done32;
  logic [2:0]  funct3In32;
  logic [31:0] srcA32, srcB32, result32;
  logic [4:0]  rdIn32, rdOut32;

  logic        start64, busy64, done64;
  logic [2:0]  funct3In64;
  logic [63:0] srcA64, srcB64, result64;
  logic [4:0]  rdIn64, rdOut64;

  int assertions = 0;
  int failures   = 0;

  riscv_mdu #(.XLEN(32), .BITS_PER_CYCLE(1)) dut32 (
    .clk(clk), .reset(reset), .StartE(start32), .funct3E(funct3In32),
    .SrcAE(srcA32), .SrcBE(srcB32), .RdE(rdIn32), .Flush(flush),
    .MulBusy(busy32), .MulDone(done32), .MulResult(result32), .MulRd(rdOut32)
  );

  riscv_mdu #(.XLEN(64), .BITS_PER_CYCLE(4)) dut64 (
    .clk(clk), .reset(reset), .StartE(start64), .funct3E(funct3In64),
    .SrcAE(srcA64), .SrcBE(srcB64), .RdE(rdIn64), .Flush(flush),
    .MulBusy(busy64), .MulDone(done64), .MulResult(result64), .MulRd(rdOut64)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assertions++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Issue one op in the current cycle and wait (bounded) for MulDone.
  task automatic applyStimulus(input bit wide, input logic [2:0] f3,
                               input logic [63:0] a, input logic [63:0] b,
                               input logic [4:0] rd, output logic [63:0] res,
                               output logic [4:0] rdOut, output int lat,
                               output int busyCyc, output logic busyAtDone);
    logic doneNow;
    if (wide) begin
      start64 = 1'b1; funct3In64 = f3; srcA64 = a; srcB64 = b; rdIn64 = rd;
    end else begin
      start32 = 1'b1; funct3In32 = f3; srcA32 = a[31:0]; srcB32 = b[31:0]; rdIn32 = rd;
    end
    #1;
    busyCyc = (wide ? busy64 : busy32) ? 1 : 0;
    @(negedge clk);
    start32 = 1'b0;
    start64 = 1'b0;
    lat = 1;
    doneNow = wide ? done64 : done32;
    while (!doneNow && lat < 100) begin
      if (wide ? busy64 : busy32) busyCyc++;
      @(negedge clk);
      lat++;
      doneNow = wide ? done64 : done32;
    end
    res        = wide ? result64 : {32'b0, result32};
    rdOut      = wide ? rdOut64 : rdOut32;
    busyAtDone = wide ? busy64 : busy32;
  endtask

  task automatic doOp(input string tag, input bit wide, input logic [2:0] f3,
                      input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
                      input logic [63:0] expRes, input int expLat);
    logic [63:0] res;
    logic [4:0]  rdOut;
    int          lat, busyCyc;
    logic        busyAtDone;
    applyStimulus(wide, f3, a, b, rd, res, rdOut, lat, busyCyc, busyAtDone);
    checkOutput({tag, ".result"}, res, expRes);
    checkOutput({tag, ".doneCycle"}, 64'(lat), 64'(expLat));
    checkOutput({tag, ".rd"}, {59'b0, rdOut}, {59'b0, rd});
    checkOutput({tag, ".busyCycles"}, 64'(busyCyc), 64'(expLat));
    checkOutput({tag, ".busyAtDone"}, {63'b0, busyAtDone}, 64'd0);
    @(negedge clk);
  endtask

  function automatic logic [63:0] refModel(input logic [2:0] f3, input logic [63:0] a,
                                           input logic [63:0] b, input bit w);
    logic [127:0]       sa, sb, ua, ub, p;
    logic signed [63:0] sA, sB;
    logic [63:0]        mask;
    logic               ovf;
    mask = w ? {64{1'b1}} : 64'h0000_0000_FFFF_FFFF;
    ua = {64'b0, a};
    ub = {64'b0, b};
    if (w) begin
      sA = a; sB = b;
    end else begin
      sA = {{32{a[31]}}, a[31:0]}; sB = {{32{b[31]}}, b[31:0]};
    end
    sa = {{64{sA[63]}}, sA};
    sb = {{64{sB[63]}}, sB};
    ovf = w ? (a == 64'h8000_0000_0000_0000 && b == mask)
            : (a == 64'h0000_0000_8000_0000 && b == mask);
    p = '0;
    case (f3)
      3'b000: begin p = sa * sb; return p[63:0] & mask; end
      3'b001: p = sa * sb;
      3'b010: p = sa * ub;
      3'b011: p = ua * ub;
      3'b100: begin
        if (b == 0) return mask;
        if (ovf) return a;
        return 64'(sA / sB) & mask;
      end
      3'b101: begin
        if (b == 0) return mask;
        return a / b;
      end
      3'b110: begin
        if (b == 0) return a;
        if (ovf) return 64'd0;
        return 64'(sA % sB) & mask;
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
    return w ? p[127:64] : {32'b0, p[63:32]};
  endfunction

  function automatic int refLatency(input logic [2:0] f3, input logic [63:0] a,
                                    input logic [63:0] b, input bit w);
    logic fast;
    fast = f3[2] && ((b == 0) ||
           (!f3[0] && (w ? (a == 64'h8000_0000_0000_0000 && b == {64{1'b1}})
                         : (a == 64'h0000_0000_8000_0000 && b == 64'h0000_0000_FFFF_FFFF))));
    return fast ? 1 : (w ? 17 : 33);
  endfunction

  function automatic logic [63:0] pickOperand(input bit w);
    logic [63:0] v;
    int          sel;
    sel = int'($urandom_range(0, 5));
    case (sel)
      0:       v = 64'd0;
      1:       v = {64{1'b1}};
      2:       v = 64'h8000_0000_0000_0000;
      3:       v = 64'($urandom_range(1, 20));
      default: v = {$urandom, $urandom};
    endcase
    if (!w) v = (sel == 2) ? 64'h0000_0000_8000_0000 : {32'b0, v[31:0]};
    return v;
  endfunction

  initial begin
    logic        sawDone;
    logic [2:0]  f;
    logic [63:0] a, b;
    bit          w;

    reset = 1'b1; flush = 1'b0;
    start32 = 1'b0; funct3In32 = '0; srcA32 = '0; srcB32 = '0; rdIn32 = '0;
    start64 = 1'b0; funct3In64 = '0; srcA64 = '0; srcB64 = '0; rdIn64 = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset.busy32", {63'b0, busy32}, 64'd0);
    checkOutput("reset.done32", {63'b0, done32}, 64'd0);
    checkOutput("reset.result32", {32'b0, result32}, 64'd0);
    checkOutput("reset.rd32", {59'b0, rdOut32}, 64'd0);
    checkOutput("reset.busy64", {63'b0, busy64}, 64'd0);
    checkOutput("reset.result64", result64, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Multiply family, 32-bit.
    doOp("mul",    0, 3'b000, 64'd7,        64'hFFFF_FFFD, 5'd5, 64'hFFFF_FFEB, 33);
    doOp("mulh",   0, 3'b001, 64'h8000_0000, 64'h8000_0000, 5'd6, 64'h4000_0000, 33);
    doOp("mulhu",  0, 3'b011, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 5'd7, 64'hFFFF_FFFE, 33);
    doOp("mulhsu", 0, 3'b010, 64'hFFFF_FFFF, 64'd2,         5'd8, 64'hFFFF_FFFF, 33);

    // Divide family, 32-bit.
    doOp("div",  0, 3'b100, 64'hFFFF_FFF9, 64'd2, 5'd10, 64'hFFFF_FFFD, 33);
    doOp("rem",  0, 3'b110, 64'hFFFF_FFF9, 64'd2, 5'd11, 64'hFFFF_FFFF, 33);
    doOp("divu", 0, 3'b101, 64'd100,       64'd7, 5'd12, 64'd14, 33);
    doOp("remu", 0, 3'b111, 64'd100,       64'd7, 5'd13, 64'd2, 33);

    // Divide corner cases take the one-cycle path.
    doOp("div0",   0, 3'b100, 64'd5,         64'd0,         5'd14, 64'hFFFF_FFFF, 1);
    doOp("remu0",  0, 3'b111, 64'd5,         64'd0,         5'd15, 64'd5, 1);
    doOp("rem0",   0, 3'b110, 64'hFFFF_FFF9, 64'd0,         5'd16, 64'hFFFF_FFF9, 1);
    doOp("divovf", 0, 3'b100, 64'h8000_0000, 64'hFFFF_FFFF, 5'd17, 64'h8000_0000, 1);
    doOp("removf", 0, 3'b110, 64'h8000_0000, 64'hFFFF_FFFF, 5'd18, 64'd0, 1);

    // Start presented together with Flush is dropped.
    start32 = 1'b1; flush = 1'b1; funct3In32 = 3'b000; srcA32 = 32'd3; srcB32 = 32'd3;
    #1;
    checkOutput("flushStart.busyIssue", {63'b0, busy32}, 64'd0);
    @(negedge clk);
    start32 = 1'b0; flush = 1'b0;
    checkOutput("flushStart.busyNext", {63'b0, busy32}, 64'd0);
    checkOutput("flushStart.doneNext", {63'b0, done32}, 64'd0);
    @(negedge clk);

    // Flush a DIVU at t+10, then start a MUL at t+11.
    funct3In32 = 3'b101; srcA32 = 32'd100; srcB32 = 32'd7; rdIn32 = 5'd20; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    sawDone = 1'b0;
    repeat (9) begin
      if (done32) sawDone = 1'b1;
      @(negedge clk);
    end
    if (done32) sawDone = 1'b1;
    flush = 1'b1;
    #1;
    checkOutput("flush.busyAtFlush", {63'b0, busy32}, 64'd1);
    @(negedge clk);
    flush = 1'b0;
    #1;
    checkOutput("flush.busyAfter", {63'b0, busy32}, 64'd0);
    checkOutput("flush.noEarlyDone", {63'b0, sawDone}, 64'd0);
    doOp("mulAfterFlush", 0, 3'b000, 64'd3, 64'd5, 5'd21, 64'd15, 33);

    // Reset in the middle of an iteration.
    funct3In32 = 3'b000; srcA32 = 32'd9; srcB32 = 32'd9; rdIn32 = 5'd22; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("midReset.busyBefore", {63'b0, busy32}, 64'd1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midReset.busy", {63'b0, busy32}, 64'd0);
    checkOutput("midReset.done", {63'b0, done32}, 64'd0);
    checkOutput("midReset.result", {32'b0, result32}, 64'd0);
    checkOutput("midReset.rd", {59'b0, rdOut32}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // 64-bit, 4 bits per cycle.
    doOp("mulhu64", 1, 3'b011, {64{1'b1}}, {64{1'b1}}, 5'd3, 64'hFFFF_FFFF_FFFF_FFFE, 17);
    doOp("mul64",   1, 3'b000, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 5'd4, 64'hFFFF_FFFF_FFFF_FFEB, 17);
    doOp("div64",   1, 3'b100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd9, 64'hFFFF_FFFF_FFFF_FFFD, 17);
    doOp("divovf64", 1, 3'b100, 64'h8000_0000_0000_0000, {64{1'b1}}, 5'd1,
         64'h8000_0000_0000_0000, 1);

    // Mixed sweep alternating widths, checked against the behavioural model.
    for (int i = 0; i < 48; i++) begin
      w = (i % 2) == 1;
      f = 3'($urandom_range(0, 7));
      a = pickOperand(w);
      b = pickOperand(w);
      doOp($sformatf("sweep%0d_f%0d", i, f), w, f, a, b, 5'(i),
           refModel(f, a, b, w), refLatency(f, a, b, w));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
